// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - sample handshake and I2S serial lines for i2s_tx
interface i2s_tx_if;
  logic        en;
  logic [23:0] lft_in;
  logic [23:0] rght_in;
  logic        vld;
  logic        smpl_req;
  logic        underrun;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;

  modport master (
    output en, lft_in, rght_in, vld,
    input  smpl_req, underrun, I2S_sclk, I2S_ws, I2S_data
  );

  modport slave (
    input  en, lft_in, rght_in, vld,
    output smpl_req, underrun, I2S_sclk, I2S_ws, I2S_data
  );
endinterface

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - 24-bit Philips I2S transmitter, 32 clk sclk, 64 bits per frame
// I2S_TX_UNDERRUN_MUTE_EN: an underrun frame sends zeros instead of repeating the last pair.
module i2s_tx (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [4:0]  sclk_div_q;
  logic [5:0]  bit_cnt_q;
  logic [5:0]  bit_cnt_d;
  logic        ws_q;
  logic        data_q;
  logic        smpl_req_q;
  logic        underrun_q;
  logic        vld_seen_q;
  logic        first_q;
  logic [23:0] hold_l_q;
  logic [23:0] hold_r_q;
  logic [23:0] shift_l_q;
  logic [23:0] shift_r_q;
  logic [23:0] load_l;
  logic [23:0] load_r;
  logic [23:0] slot_smp;
  logic [4:0]  slot_k;
  logic [4:0]  slot_idx;
  logic        fall_evt;
  logic        wrap;
  logic        frame_start;
  logic        starve;
  logic        slot_bit;

  assign fall_evt    = (state_q == RUN) && (sclk_div_q == 5'd31);
  assign wrap        = fall_evt && (bit_cnt_q == 6'd63);
  assign frame_start = bus.en && ((state_q == IDLE) || wrap);
  // The first frame after reset has no earlier frame start, so it cannot underrun.
  assign starve      = frame_start && !vld_seen_q && !first_q;

  assign bit_cnt_d = bit_cnt_q + 6'd1;
  assign slot_k    = bit_cnt_d[4:0];
  assign slot_idx  = 5'd24 - slot_k;
  assign slot_smp  = bit_cnt_d[5] ? shift_r_q : shift_l_q;
  assign slot_bit  = (slot_k >= 5'd1 && slot_k <= 5'd24) ? slot_smp[slot_idx] : 1'b0;

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  assign load_l = starve ? 24'd0 : hold_l_q;
  assign load_r = starve ? 24'd0 : hold_r_q;
`else
  assign load_l = hold_l_q;
  assign load_r = hold_r_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_div_q <= 5'd0;
      bit_cnt_q  <= 6'd0;
      ws_q       <= 1'b1;
      data_q     <= 1'b0;
      smpl_req_q <= 1'b0;
      underrun_q <= 1'b0;
      vld_seen_q <= 1'b0;
      first_q    <= 1'b1;
      hold_l_q   <= 24'd0;
      hold_r_q   <= 24'd0;
      shift_l_q  <= 24'd0;
      shift_r_q  <= 24'd0;
    end else begin
      smpl_req_q <= 1'b0;
      if (bus.vld) begin
        hold_l_q <= bus.lft_in;
        hold_r_q <= bus.rght_in;
      end
      // A vld coincident with a load belongs to the next frame.
      vld_seen_q <= frame_start ? bus.vld : (vld_seen_q | bus.vld);
      if (frame_start) begin
        shift_l_q  <= load_l;
        shift_r_q  <= load_r;
        smpl_req_q <= 1'b1;
        first_q    <= 1'b0;
        if (starve) begin
          underrun_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          sclk_div_q <= 5'd0;
          if (bus.en) begin
            state_q   <= RUN;
            bit_cnt_q <= 6'd0;
            ws_q      <= 1'b0;
            data_q    <= 1'b0;
          end
        end
        RUN: begin
          sclk_div_q <= sclk_div_q + 5'd1;
          if (fall_evt) begin
            if (wrap && !bus.en) begin
              state_q   <= IDLE;
              bit_cnt_q <= 6'd0;
              ws_q      <= 1'b1;
              data_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_d;
              ws_q      <= bit_cnt_d[5];
              data_q    <= slot_bit;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.smpl_req = smpl_req_q;
  assign bus.underrun = underrun_q;
  assign bus.I2S_sclk = sclk_div_q[4];
  assign bus.I2S_ws   = ws_q;
  assign bus.I2S_data = data_q;
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 en  input  1  stream enable; level-sensitive.
REQ-004 lft_in  input  24  left sample, two's complement.
REQ-005 rght_in  input  24  right sample, two's complement.
REQ-006 vld  input  1  single-clk strobe; SHALL capture lft_in/rght_in into holding registers.
REQ-007 smpl_req  output  1  single-clk pulse at frame start; holding registers consumed, next sample wanted.
REQ-008 underrun  output  1  sticky; a frame started with no vld since the previous frame start.
REQ-009 I2S_sclk  output  1  serial bit clock.
REQ-010 I2S_ws  output  1  word select; 0 = left slot, 1 = right slot.
REQ-011 I2S_data  output  1  serial data, MSB first.

Function
REQ-012 States: IDLE, RUN; IDLE->RUN on clk with en=1; RUN->IDLE only at a frame wrap (bit_cnt 63->0) with en=0; en dropping mid-frame SHALL complete the current frame.
REQ-013 5-bit sclk_div SHALL be cleared in IDLE and increment every clk in RUN; I2S_sclk = sclk_div[4] (32 clk period, 50% duty).
REQ-014 "Fall event" = clk where sclk_div==31; I2S_ws, I2S_data and 6-bit bit_cnt SHALL update only on fall events (or on RUN entry).
REQ-015 bit_cnt SHALL increment on each fall event, wrapping 63->0; I2S_ws = bit_cnt[5] (32 bits per slot, 64 per frame).
REQ-016 Slot bit k = bit_cnt[4:0]: k=0 drives 0 (one-bit Philips delay); k=1..24 drive sample[24-k]; k=25..31 drive 0.
REQ-017 Frame start (RUN entry or 63->0 wrap with en=1): shift registers SHALL load from holding registers, smpl_req SHALL pulse high for exactly one clk.
REQ-018 RUN entry SHALL set sclk_div=0, bit_cnt=0, I2S_ws=0, I2S_data=0 on the entry clk.
REQ-019 vld on the same clk as a frame-start load: the load SHALL take the old holding values; new values are held for the next frame.
REQ-020 vld during IDLE SHALL update holding registers; vld with en=0 is legal.
REQ-021 Frame start with no vld since previous frame start (first frame after reset exempt) SHALL set underrun; cleared only by rst.
REQ-022 Right sample SHALL be latched at the same frame start as the left sample (no channel tearing).

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, I2S_sclk=0, I2S_ws=1, I2S_data=0, smpl_req=0, underrun=0, counters=0, holding and shift registers=0.
REQ-024 Reset mid-frame SHALL abort the frame; no partial smpl_req pulse after rst release.

Configuration
REQ-025 Macro I2S_TX_UNDERRUN_MUTE_EN: defined -> an underrun frame SHALL transmit all-zero left and right samples; undefined -> it SHALL retransmit the previous sample pair. underrun flag behaviour identical in both builds.

Verification
REQ-026 rst release, en=1, vld with lft=24'hA5A5A5, rght=24'h5A5A5A before entry -> ws low 32 sclk, data bits 1..24 = A5A5A5 MSB first, ws high, then 5A5A5A; smpl_req every 2048 clks.
REQ-027 Measure I2S_sclk -> period 32 clks, high 16; ws edges coincide with sclk falling edges only.
REQ-028 Withhold vld for one frame -> underrun=1 and stays 1; MUTE_EN build sends 0 both slots, non-MUTE build repeats previous pair.
REQ-029 Drop en at bit_cnt=10 -> frame completes to bit 63, then IDLE, I2S_sclk held 0, no further smpl_req.
REQ-030 Assert rst at bit_cnt=40 -> same clk outputs reach reset values (ws=1); after release and en=1 new frame starts at bit 0 with smpl_req.
REQ-031 Issue vld coincident with smpl_req, lft=24'h800001 -> current frame carries the old sample, next frame carries 800001.
